// File: rtl/data_unloader_8.sv
// rtl/data_unloader_8.sv - APF bridge 32-bit read serviced as four sequential byte reads
// from an 8-bit synchronous memory with configurable read latency.
module data_unloader_8 #(
  parameter logic [3:0] ADDRESS_MASK_UPPER_4 = 4'h1,
  parameter int         ADDRESS_SIZE         = 15,
  parameter int         READ_MEM_CLOCK_DELAY = 1
) (
  input  logic                  clk_74a,
  input  logic                  reset,
  input  logic                  bridge_rd,
  input  logic                  bridge_endian_little,
  input  logic [31:0]           bridge_addr,
  output logic [31:0]           bridge_rd_data,
  output logic                  read_busy,
  output logic                  read_done,
  output logic                  read_en,
  output logic [ADDRESS_SIZE:0] read_addr,
  input  logic [7:0]            read_data
);

  localparam int         AW    = ADDRESS_SIZE + 1;
  localparam logic [3:0] DELAY = 4'(READ_MEM_CLOCK_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [AW-1:0]   r_base;
  logic [AW-1:0]   r_read_addr;
  logic            r_little;
  logic [1:0]      r_idx;
  logic [3:0]      r_delay;
  logic [2:0][7:0] r_lane;
  logic [31:0]     r_rd_data;

  logic            w_accept;
  logic            w_beat_done;
  logic [1:0]      w_next_idx;
  logic [AW-1:0]   w_next_addr;
  logic [31:0]     w_word;
  logic            w_unused_addr;

  assign w_accept      = bridge_rd && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4) &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_beat_done   = (r_state == S_WAIT) && (r_delay == 4'd1);
  assign w_next_idx    = r_idx + 2'd1;
  assign w_next_addr   = r_base + AW'(w_next_idx);
  assign w_unused_addr = ^bridge_addr[27:AW];

  // Byte 3 is taken straight off the memory bus so the word is ready as DONE begins.
  assign w_word = r_little ? {read_data, r_lane[2], r_lane[1], r_lane[0]}
                           : {r_lane[0], r_lane[1], r_lane[2], read_data};

  assign bridge_rd_data = r_rd_data;
  assign read_addr      = r_read_addr;

  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (w_beat_done) w_next_state = (r_idx == 2'd3) ? S_DONE : S_ISSUE;
      S_DONE:  w_next_state = w_accept ? S_ISSUE : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    read_en   = 1'b0;
    read_busy = 1'b0;
    read_done = 1'b0;
    case (r_state)
      S_ISSUE: begin
        read_en   = 1'b1;
        read_busy = 1'b1;
      end
      S_WAIT:  read_busy = 1'b1;
      S_DONE:  read_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_read_addr <= '0;
      r_little    <= 1'b0;
      r_idx       <= 2'd0;
      r_delay     <= 4'd0;
      r_lane      <= '0;
      r_rd_data   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_base      <= bridge_addr[AW-1:0];
        r_read_addr <= bridge_addr[AW-1:0];
        r_little    <= bridge_endian_little;
        r_idx       <= 2'd0;
      end
      if (r_state == S_ISSUE) begin
        r_delay <= DELAY;
      end
      if (r_state == S_WAIT) begin
        r_delay <= r_delay - 4'd1;
        if (w_beat_done) begin
          if (r_idx != 2'd3) begin
            r_lane[r_idx] <= read_data;
            r_idx         <= w_next_idx;
            r_read_addr   <= w_next_addr;
          end else begin
            r_rd_data <= w_word;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_unloader_8.sv
// tb/tb_data_unloader_8.sv - self-checking bench: D=1 and D=3 instances against a cycle-schedule
// and byte-assembly reference model with randomized addresses, endianness and memory contents.
module tb_data_unloader_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_rd;
  logic        b_little;
  logic [31:0] b_addr;
  logic [1:0]  ren, rbusy, rdone;
  logic [15:0] raddr [2];
  logic [31:0] rdata [2];
  logic [7:0]  mdata [2];
  logic [7:0]  mem [0:65535];
  logic [7:0]  p1;
  logic [7:0]  p3 [3];

  int checks = 0;
  int errors = 0;
  int dly [2] = '{1, 3};

  logic [63:0]  en_obs [2], en_exp [2], done_obs [2], done_exp [2], busy_obs [2], busy_exp [2];
  logic [127:0] addr_obs [2], addr_exp [2];
  logic [63:0]  word_obs [2], word_exp [2];
  int           held_bad [2];

  always #5 clk = ~clk;

  // Memory models: requested byte valid exactly D cycles after read_en, garbage otherwise.
  always @(posedge clk) begin
    p1    <= ren[0] ? mem[raddr[0]] : 8'($urandom);
    p3[0] <= ren[1] ? mem[raddr[1]] : 8'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mdata[0] = p1;
  assign mdata[1] = p3[2];

  data_unloader_8 #(.ADDRESS_MASK_UPPER_4(4'h1), .ADDRESS_SIZE(15), .READ_MEM_CLOCK_DELAY(1)) u_d1 (
    .clk_74a(clk), .reset(rst), .bridge_rd(b_rd), .bridge_endian_little(b_little),
    .bridge_addr(b_addr), .bridge_rd_data(rdata[0]), .read_busy(rbusy[0]), .read_done(rdone[0]),
    .read_en(ren[0]), .read_addr(raddr[0]), .read_data(mdata[0]));

  data_unloader_8 #(.ADDRESS_MASK_UPPER_4(4'h1), .ADDRESS_SIZE(15), .READ_MEM_CLOCK_DELAY(3)) u_d3 (
    .clk_74a(clk), .reset(rst), .bridge_rd(b_rd), .bridge_endian_little(b_little),
    .bridge_addr(b_addr), .bridge_rd_data(rdata[1]), .read_busy(rbusy[1]), .read_done(rdone[1]),
    .read_en(ren[1]), .read_addr(raddr[1]), .read_data(mdata[1]));

  // Request at cycle 0 (a0), optional second request at cycle e_cyc; model builds expected
  // schedule from the timing rules, then the stimulus loop records what the DUTs did.
  task automatic do_read(input logic [31:0] a0, input logic l, input int e_cyc,
                         input logic [31:0] e_addr, input int ncyc);
    logic [31:0] held [2];
    for (int j = 0; j < 2; j++) begin
      int free_at;
      free_at = 0;
      en_exp[j] = '0; done_exp[j] = '0; busy_exp[j] = '0; addr_exp[j] = '0; word_exp[j] = '0;
      en_obs[j] = '0; done_obs[j] = '0; busy_obs[j] = '0; addr_obs[j] = '0; word_obs[j] = '0;
      held_bad[j] = 0;
      for (int r = 0; r < 2; r++) begin
        int          c;
        logic [31:0] a;
        logic [7:0]  b [4];
        c = (r == 0) ? 0 : e_cyc;
        a = (r == 0) ? a0 : e_addr;
        if ((r == 0 || e_cyc > 0) && a[31:28] == 4'h1 && c >= free_at) begin
          for (int k = 0; k < 4; k++) begin
            int t;
            t = c + 1 + k * (dly[j] + 1);
            b[k] = mem[a[15:0] + 16'(k)];
            if (t <= ncyc) begin
              en_exp[j][t] = 1'b1;
              addr_exp[j] = {addr_exp[j][111:0], a[15:0] + 16'(k)};
            end
          end
          for (int t = c + 1; t <= c + 4 * dly[j] + 4 && t <= ncyc; t++) busy_exp[j][t] = 1'b1;
          if (c + 4 * dly[j] + 5 <= ncyc) begin
            done_exp[j][c + 4 * dly[j] + 5] = 1'b1;
            word_exp[j] = {word_exp[j][31:0],
                           l ? {b[3], b[2], b[1], b[0]} : {b[0], b[1], b[2], b[3]}};
          end
          free_at = c + 4 * dly[j] + 5;
        end
      end
    end
    @(negedge clk);
    for (int j = 0; j < 2; j++) held[j] = rdata[j];
    b_rd = 1'b1; b_addr = a0; b_little = l;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        en_obs[j][cyc]   = ren[j];
        busy_obs[j][cyc] = rbusy[j];
        done_obs[j][cyc] = rdone[j];
        if (ren[j]) addr_obs[j] = {addr_obs[j][111:0], raddr[j]};
        if (rdone[j]) begin
          word_obs[j] = {word_obs[j][31:0], rdata[j]};
          held[j] = rdata[j];
        end else if (rdata[j] !== held[j]) begin
          held_bad[j]++;
        end
      end
      b_rd   = (cyc == e_cyc);
      b_addr = (cyc == e_cyc) ? e_addr : a0;
    end
    b_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rd = 1'b0; b_little = 1'b0; b_addr = 32'd0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      checks++;
      if ({ren[j], rbusy[j], rdone[j], raddr[j], rdata[j]} !== 51'd0) begin
        errors++;
        $display("FAIL reset d%0d outputs got en=%b busy=%b done=%b addr=%h data=%h want all 0",
                 dly[j], ren[j], rbusy[j], rdone[j], raddr[j], rdata[j]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_little();
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    do_read(32'h1000_0100, 1'b1, 0, 32'd0, 20);
    for (int j = 0; j < 2; j++) begin
      checks++; if (en_obs[j] !== en_exp[j]) begin errors++; $display("FAIL little d%0d read_en cycles got %h want %h", dly[j], en_obs[j], en_exp[j]); end
      checks++; if (addr_obs[j] !== addr_exp[j]) begin errors++; $display("FAIL little d%0d read_addr seq got %h want %h", dly[j], addr_obs[j], addr_exp[j]); end
      checks++; if (done_obs[j] !== done_exp[j]) begin errors++; $display("FAIL little d%0d read_done cycles got %h want %h", dly[j], done_obs[j], done_exp[j]); end
      checks++; if (busy_obs[j] !== busy_exp[j]) begin errors++; $display("FAIL little d%0d read_busy cycles got %h want %h", dly[j], busy_obs[j], busy_exp[j]); end
      checks++; if (word_obs[j][31:0] !== 32'h4433_2211) begin errors++; $display("FAIL little d%0d data got %h want 44332211", dly[j], word_obs[j][31:0]); end
      checks++; if (held_bad[j] !== 0) begin errors++; $display("FAIL little d%0d data changed outside done got %0d want 0", dly[j], held_bad[j]); end
    end
  endtask

  task automatic test_big();
    do_read(32'h1000_0100, 1'b0, 0, 32'd0, 20);
    for (int j = 0; j < 2; j++) begin
      checks++; if (en_obs[j] !== en_exp[j]) begin errors++; $display("FAIL big d%0d read_en cycles got %h want %h", dly[j], en_obs[j], en_exp[j]); end
      checks++; if (done_obs[j] !== done_exp[j]) begin errors++; $display("FAIL big d%0d read_done cycles got %h want %h", dly[j], done_obs[j], done_exp[j]); end
      checks++; if (word_obs[j][31:0] !== 32'h1122_3344) begin errors++; $display("FAIL big d%0d data got %h want 11223344", dly[j], word_obs[j][31:0]); end
    end
  endtask

  task automatic test_window_miss();
    do_read(32'h2000_0100, 1'b1, 0, 32'd0, 20);
    for (int j = 0; j < 2; j++) begin
      checks++; if (en_obs[j] !== 64'd0) begin errors++; $display("FAIL miss d%0d read_en cycles got %h want 0", dly[j], en_obs[j]); end
      checks++; if (busy_obs[j] !== 64'd0) begin errors++; $display("FAIL miss d%0d read_busy cycles got %h want 0", dly[j], busy_obs[j]); end
      checks++; if (held_bad[j] !== 0 || done_obs[j] !== 64'd0) begin errors++; $display("FAIL miss d%0d data changed got %0d done %h want 0", dly[j], held_bad[j], done_obs[j]); end
    end
    do_read(32'h1000_0100, 1'b1, 3, 32'h1000_0104, 20);
    for (int j = 0; j < 2; j++) begin
      checks++; if (en_obs[j] !== en_exp[j] || $countones(en_obs[j]) != 4) begin errors++; $display("FAIL busy_drop d%0d read_en cycles got %h want %h", dly[j], en_obs[j], en_exp[j]); end
      checks++; if (addr_obs[j] !== addr_exp[j]) begin errors++; $display("FAIL busy_drop d%0d read_addr seq got %h want %h", dly[j], addr_obs[j], addr_exp[j]); end
      checks++; if (word_obs[j] !== word_exp[j]) begin errors++; $display("FAIL busy_drop d%0d data got %h want %h", dly[j], word_obs[j], word_exp[j]); end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) mem[16'hFFFE + 16'(k)] = 8'($urandom_range(1, 255));
    do_read(32'h1000_FFFE, 1'b1, 0, 32'd0, 20);
    for (int j = 0; j < 2; j++) begin
      checks++; if (addr_obs[j][63:0] !== 64'hFFFE_FFFF_0000_0001) begin errors++; $display("FAIL wrap d%0d read_addr seq got %h want fffeffff00000001", dly[j], addr_obs[j][63:0]); end
      checks++; if (word_obs[j] !== word_exp[j]) begin errors++; $display("FAIL wrap d%0d data got %h want %h", dly[j], word_obs[j], word_exp[j]); end
    end
  endtask

  task automatic test_back_to_back();
    mem[16'h0200] = 8'hA1; mem[16'h0201] = 8'hB2; mem[16'h0202] = 8'hC3; mem[16'h0203] = 8'hD4;
    do_read(32'h1000_0200, 1'b1, 17, 32'h1000_0100, 40);
    for (int j = 0; j < 2; j++) begin
      checks++; if (en_obs[j] !== en_exp[j]) begin errors++; $display("FAIL b2b d%0d read_en cycles got %h want %h", dly[j], en_obs[j], en_exp[j]); end
      checks++; if (addr_obs[j] !== addr_exp[j]) begin errors++; $display("FAIL b2b d%0d read_addr seq got %h want %h", dly[j], addr_obs[j], addr_exp[j]); end
      checks++; if (done_obs[j] !== done_exp[j]) begin errors++; $display("FAIL b2b d%0d read_done cycles got %h want %h", dly[j], done_obs[j], done_exp[j]); end
      checks++; if (busy_obs[j] !== busy_exp[j]) begin errors++; $display("FAIL b2b d%0d read_busy cycles got %h want %h", dly[j], busy_obs[j], busy_exp[j]); end
      checks++; if (word_obs[j] !== word_exp[j]) begin errors++; $display("FAIL b2b d%0d data got %h want %h", dly[j], word_obs[j], word_exp[j]); end
    end
    checks++; if (word_obs[1][63:32] !== 32'hD4C3_B2A1 || !en_obs[1][18] || !done_obs[1][17]) begin errors++; $display("FAIL b2b d3 first data %h en18 %b done17 %b want d4c3b2a1 1 1", word_obs[1][63:32], en_obs[1][18], done_obs[1][17]); end
  endtask

  task automatic test_reset_mid();
    int stray_done;
    stray_done = 0;
    @(negedge clk);
    b_rd = 1'b1; b_addr = 32'h1000_0100; b_little = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      b_rd = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if ({ren[j], rbusy[j], rdone[j], raddr[j], rdata[j]} !== 51'd0) begin
        errors++;
        $display("FAIL reset_mid d%0d outputs got en=%b busy=%b done=%b addr=%h data=%h want all 0",
                 dly[j], ren[j], rbusy[j], rdone[j], raddr[j], rdata[j]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      stray_done += int'(rdone[0]) + int'(rdone[1]);
    end
    checks++; if (stray_done != 0) begin errors++; $display("FAIL reset_mid stray read_done got %0d want 0", stray_done); end
    do_read(32'h1000_0100, 1'b0, 0, 32'd0, 20);
    for (int j = 0; j < 2; j++) begin
      checks++; if (en_obs[j] !== en_exp[j] || done_obs[j] !== done_exp[j]) begin errors++; $display("FAIL reset_mid d%0d timing en %h done %h want %h %h", dly[j], en_obs[j], done_obs[j], en_exp[j], done_exp[j]); end
      checks++; if (word_obs[j][31:0] !== 32'h1122_3344) begin errors++; $display("FAIL reset_mid d%0d data got %h want 11223344", dly[j], word_obs[j][31:0]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [31:0] a0, ea;
      logic        l;
      int          ec;
      a0 = {4'h1, 28'($urandom)};
      ea = {($urandom_range(0, 1) == 1) ? 4'h1 : 4'($urandom), 28'($urandom)};
      l  = 1'($urandom);
      ec = $urandom_range(0, 12);
      for (int k = 0; k < 4; k++) mem[a0[15:0] + 16'(k)] = 8'($urandom);
      do_read(a0, l, ec, ea, 40);
      for (int j = 0; j < 2; j++) begin
        checks++; if (en_obs[j] !== en_exp[j]) begin errors++; $display("FAIL random%0d d%0d read_en cycles got %h want %h", it, dly[j], en_obs[j], en_exp[j]); end
        checks++; if (addr_obs[j] !== addr_exp[j]) begin errors++; $display("FAIL random%0d d%0d read_addr seq got %h want %h", it, dly[j], addr_obs[j], addr_exp[j]); end
        checks++; if (done_obs[j] !== done_exp[j]) begin errors++; $display("FAIL random%0d d%0d read_done cycles got %h want %h", it, dly[j], done_obs[j], done_exp[j]); end
        checks++; if (word_obs[j] !== word_exp[j]) begin errors++; $display("FAIL random%0d d%0d data got %h want %h", it, dly[j], word_obs[j], word_exp[j]); end
        checks++; if (held_bad[j] !== 0) begin errors++; $display("FAIL random%0d d%0d data changed outside done got %0d want 0", it, dly[j], held_bad[j]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_little();
    test_big();
    test_window_miss();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
